// File: rtl/secuenciador_registros_pkg.sv
// Shared definitions for the register-file micro-sequencer: op codes, register-file
// commands, FSM state encoding and instruction field positions.
package secuenciador_registros_pkg;

    typedef enum logic [2:0] {
        OpNop = 3'b000,
        OpLdi = 3'b001,
        OpMov = 3'b010,
        OpAlu = 3'b011,
        OpOut = 3'b100
    } op_e;

    localparam logic [1:0] CmdHold  = 2'b00;
    localparam logic [1:0] CmdWrite = 2'b01;
    localparam logic [1:0] CmdRead  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StRead,
        StCapture,
        StExec,
        StWrite,
        StDone
    } state_e;

    // Low bit of each 3-bit instruction field; bit 0 is unused.
    localparam int unsigned OpLsb   = 13;
    localparam int unsigned RdLsb   = 10;
    localparam int unsigned RxLsb   = 7;
    localparam int unsigned RyLsb   = 4;
    localparam int unsigned FuncLsb = 1;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OpOut;
    endfunction

endpackage

// File: rtl/secuenciador_registros_contador_timeout.sv
// Loadable down-counter that saturates at zero; expired_o flags a zero count.
module secuenciador_registros_contador_timeout #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [Width-1:0] cuenta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cuenta_q <= '0;
        end else if (load_i) begin
            cuenta_q <= load_value_i;
        end else if (dec_i && (cuenta_q != '0)) begin
            cuenta_q <= cuenta_q - Width'(1);
        end
    end

    assign expired_o = (cuenta_q == '0);

endmodule

// File: rtl/secuenciador_registros.sv
// Micro-sequencer for the 8x8 data register file: accepts one instruction, then sequences
// register read, optional external ALU operation and write-back. All outputs are registered.
module secuenciador_registros
    import secuenciador_registros_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic        i_Timming,
    input  logic        i_Rst,
    input  logic [15:0] i_Instruccion,
    input  logic [7:0]  i_Inmediato,
    input  logic        i_Inst_valida,
    output logic        o_Inst_lista,
    output logic [1:0]  o_Lectura_escritura,
    output logic [2:0]  o_Control_RX,
    output logic [2:0]  o_Control_RY,
    output logic [2:0]  o_Seleccion_registro_escritura,
    output logic [2:0]  o_Seleccion_registro_lectura,
    output logic [7:0]  o_Datos,
    input  logic [7:0]  i_RX,
    input  logic [7:0]  i_RY,
    output logic [7:0]  o_ALU_A,
    output logic [7:0]  o_ALU_B,
    output logic [2:0]  o_ALU_func,
    output logic        o_ALU_inicio,
    input  logic        i_ALU_listo,
    input  logic [7:0]  i_ALU_resultado,
    output logic [7:0]  o_Dato_salida,
    output logic        o_Salida_valida,
    output logic        o_Fin,
    output logic        o_Error,
    output logic [7:0]  o_Contador_inst
);

    localparam logic [7:0] TimeoutLoad = 8'(ALU_TIMEOUT - 1);

    state_e     state_q;
    logic [2:0] op_q;
    logic [2:0] rd_q;
    logic [2:0] rx_q;
    logic [2:0] ry_q;
    logic [2:0] func_q;
    logic [7:0] imm_q;

    logic timeout_load;
    logic timeout_dec;
    logic timeout_expired;
    logic unused_bit;

    assign unused_bit   = i_Instruccion[0];
    assign timeout_load = (state_q == StCapture) && (op_q == OpAlu);
    assign timeout_dec  = (state_q == StExec);

    // Gated by reset so the ready flag is low while reset is held.
    assign o_Inst_lista = (state_q == StIdle) && !i_Rst;

    secuenciador_registros_contador_timeout #(
        .Width(8)
    ) u_contador_timeout (
        .clk_i       (i_Timming),
        .rst_i       (i_Rst),
        .load_i      (timeout_load),
        .load_value_i(TimeoutLoad),
        .dec_i       (timeout_dec),
        .expired_o   (timeout_expired)
    );

    // Outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge i_Timming or posedge i_Rst) begin
        if (i_Rst) begin
            state_q                        <= StIdle;
            op_q                           <= '0;
            rd_q                           <= '0;
            rx_q                           <= '0;
            ry_q                           <= '0;
            func_q                         <= '0;
            imm_q                          <= '0;
            o_Lectura_escritura            <= CmdHold;
            o_Control_RX                   <= '0;
            o_Control_RY                   <= '0;
            o_Seleccion_registro_escritura <= '0;
            o_Seleccion_registro_lectura   <= '0;
            o_Datos                        <= '0;
            o_ALU_A                        <= '0;
            o_ALU_B                        <= '0;
            o_ALU_func                     <= '0;
            o_ALU_inicio                   <= 1'b0;
            o_Dato_salida                  <= '0;
            o_Salida_valida                <= 1'b0;
            o_Fin                          <= 1'b0;
            o_Error                        <= 1'b0;
            o_Contador_inst                <= '0;
        end else begin
            o_Lectura_escritura            <= CmdHold;
            o_Control_RX                   <= '0;
            o_Control_RY                   <= '0;
            o_Seleccion_registro_escritura <= '0;
            o_Seleccion_registro_lectura   <= '0;
            o_Datos                        <= '0;
            o_ALU_inicio                   <= 1'b0;
            o_Salida_valida                <= 1'b0;
            o_Fin                          <= 1'b0;
            o_Error                        <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (i_Inst_valida) begin
                        op_q    <= i_Instruccion[OpLsb +: 3];
                        rd_q    <= i_Instruccion[RdLsb +: 3];
                        rx_q    <= i_Instruccion[RxLsb +: 3];
                        ry_q    <= i_Instruccion[RyLsb +: 3];
                        func_q  <= i_Instruccion[FuncLsb +: 3];
                        imm_q   <= i_Inmediato;
                        // Illegal ops flag on the DECODE cycle itself.
                        o_Error <= !op_legal(i_Instruccion[OpLsb +: 3]);
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    case (op_q)
                        OpNop: begin
                            o_Fin           <= 1'b1;
                            o_Contador_inst <= o_Contador_inst + 8'd1;
                            state_q         <= StDone;
                        end
                        OpLdi: begin
                            o_Lectura_escritura            <= CmdWrite;
                            o_Seleccion_registro_escritura <= rd_q;
                            o_Datos                        <= imm_q;
                            state_q                        <= StWrite;
                        end
                        OpMov, OpAlu, OpOut: begin
                            o_Lectura_escritura          <= CmdRead;
                            o_Control_RX                 <= rx_q;
                            o_Control_RY                 <= ry_q;
                            o_Seleccion_registro_lectura <= rx_q;
                            state_q                      <= StRead;
                        end
                        default: state_q <= StIdle;
                    endcase
                end
                StRead: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    case (op_q)
                        OpMov: begin
                            o_Lectura_escritura            <= CmdWrite;
                            o_Seleccion_registro_escritura <= rd_q;
                            o_Datos                        <= i_RX;
                            state_q                        <= StWrite;
                        end
                        OpOut: begin
                            o_Dato_salida   <= i_RX;
                            o_Salida_valida <= 1'b1;
                            o_Fin           <= 1'b1;
                            o_Contador_inst <= o_Contador_inst + 8'd1;
                            state_q         <= StDone;
                        end
                        default: begin
                            o_ALU_A      <= i_RX;
                            o_ALU_B      <= i_RY;
                            o_ALU_func   <= func_q;
                            o_ALU_inicio <= 1'b1;
                            state_q      <= StExec;
                        end
                    endcase
                end
                StExec: begin
                    if (i_ALU_listo) begin
                        o_Lectura_escritura            <= CmdWrite;
                        o_Seleccion_registro_escritura <= rd_q;
                        o_Datos                        <= i_ALU_resultado;
                        o_ALU_A                        <= '0;
                        o_ALU_B                        <= '0;
                        o_ALU_func                     <= '0;
                        state_q                        <= StWrite;
                    end else if (timeout_expired) begin
                        o_Error    <= 1'b1;
                        o_ALU_A    <= '0;
                        o_ALU_B    <= '0;
                        o_ALU_func <= '0;
                        state_q    <= StIdle;
                    end
                end
                StWrite: begin
                    o_Fin           <= 1'b1;
                    o_Contador_inst <= o_Contador_inst + 8'd1;
                    state_q         <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_registros.sv
// Directed self-checking bench for secuenciador_registros with a small register-file model.
module tb_secuenciador_registros;

    logic        clk, rst;
    logic [15:0] instr;
    logic [7:0]  imm;
    logic        valid, lista;
    logic [1:0]  cmd;
    logic [2:0]  ctl_rx, ctl_ry, sel_wr, sel_rd;
    logic [7:0]  datos, rx_out, ry_out, alu_a, alu_b;
    logic [2:0]  alu_func;
    logic        alu_inicio, alu_listo;
    logic [7:0]  alu_res, dato_sal;
    logic        sal_val, fin, error;
    logic [7:0]  cont;

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;
    int wr_cnt = 0;
    int inicio_cnt = 0;
    logic [7:0] regs [8];

    secuenciador_registros #(.ALU_TIMEOUT(15)) dut (
        .i_Timming                     (clk),
        .i_Rst                         (rst),
        .i_Instruccion                 (instr),
        .i_Inmediato                   (imm),
        .i_Inst_valida                 (valid),
        .o_Inst_lista                  (lista),
        .o_Lectura_escritura           (cmd),
        .o_Control_RX                  (ctl_rx),
        .o_Control_RY                  (ctl_ry),
        .o_Seleccion_registro_escritura(sel_wr),
        .o_Seleccion_registro_lectura  (sel_rd),
        .o_Datos                       (datos),
        .i_RX                          (rx_out),
        .i_RY                          (ry_out),
        .o_ALU_A                       (alu_a),
        .o_ALU_B                       (alu_b),
        .o_ALU_func                    (alu_func),
        .o_ALU_inicio                  (alu_inicio),
        .i_ALU_listo                   (alu_listo),
        .i_ALU_resultado               (alu_res),
        .o_Dato_salida                 (dato_sal),
        .o_Salida_valida               (sal_val),
        .o_Fin                         (fin),
        .o_Error                       (error),
        .o_Contador_inst               (cont)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: reads appear the cycle after a READ command.
    initial for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    always @(posedge clk) begin
        if (cmd == 2'b01) regs[sel_wr] <= datos;
        if (cmd == 2'b10) begin
            rx_out <= regs[ctl_rx];
            ry_out <= regs[ctl_ry];
        end
    end

    always @(negedge clk) begin
        if (fin) fin_cnt <= fin_cnt + 1;
        if (cmd == 2'b01) wr_cnt <= wr_cnt + 1;
        if (alu_inicio) inicio_cnt <= inicio_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rx, input logic [2:0] ry,
                                        input logic [2:0] fn);
        return {op, rd, rx, ry, fn, 1'b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!lista && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("wait_idle", 32'(lista), 32'd1);
    endtask

    // Offer at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [15:0] ins, input logic [7:0] im);
        wait_idle();
        instr = ins;
        imm   = im;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        instr = '0;
        imm   = '0;
    endtask

    int snap;

    initial begin
        rst = 1'b1; valid = 1'b0; instr = '0; imm = '0; alu_listo = 1'b0; alu_res = '0;
        rx_out = '0; ry_out = '0;
        #2;
        check_value("rst_lista", 32'(lista), 0);
        check_value("rst_cmd", 32'(cmd), 0);
        check_value("rst_cont", 32'(cont), 0);
        cyc(2);
        rst = 1'b0;
        #1;
        check_value("release_lista", 32'(lista), 1);
        check_value("release_cont", 32'(cont), 0);
        cyc(1);

        // LDI R3 <- E7
        issue(enc(3'b001, 3'd3, 3'd0, 3'd0, 3'd0), 8'hE7);
        cyc(1); check_value("ldi_c1_cmd", 32'(cmd), 0);
        cyc(1); check_value("ldi_wr_cmd", 32'(cmd), 1);
        check_value("ldi_wr_addr", 32'(sel_wr), 3);
        check_value("ldi_wr_data", 32'(datos), 32'hE7);
        check_value("ldi_c2_fin", 32'(fin), 0);
        cyc(1); check_value("ldi_fin", 32'(fin), 1);
        check_value("ldi_cont", 32'(cont), 1);
        cyc(1); check_value("ldi_fin_pulse", 32'(fin), 0);
        check_value("ldi_idle", 32'(lista), 1);

        // MOV R5 <- R3
        issue(enc(3'b010, 3'd5, 3'd3, 3'd0, 3'd0), 8'h00);
        cyc(2); check_value("mov_rd_cmd", 32'(cmd), 2);
        check_value("mov_rd_rx", 32'(ctl_rx), 3);
        check_value("mov_rd_sel", 32'(sel_rd), 3);
        cyc(1); check_value("mov_cap_cmd", 32'(cmd), 0);
        check_value("mov_cap_sel", 32'(sel_rd), 0);
        cyc(1); check_value("mov_wr_cmd", 32'(cmd), 1);
        check_value("mov_wr_addr", 32'(sel_wr), 5);
        check_value("mov_wr_data", 32'(datos), 32'hE7);
        cyc(1); check_value("mov_fin", 32'(fin), 1);
        check_value("mov_cont", 32'(cont), 2);

        // OUT R5
        issue(enc(3'b100, 3'd0, 3'd5, 3'd0, 3'd0), 8'h00);
        cyc(3); check_value("out_c3_val", 32'(sal_val), 0);
        cyc(1); check_value("out_fin", 32'(fin), 1);
        check_value("out_val", 32'(sal_val), 1);
        check_value("out_data", 32'(dato_sal), 32'hE7);
        check_value("out_cont", 32'(cont), 3);
        cyc(1); check_value("out_val_pulse", 32'(sal_val), 0);
        check_value("out_data_held", 32'(dato_sal), 32'hE7);

        // LDI R1 <- 12
        issue(enc(3'b001, 3'd1, 3'd0, 3'd0, 3'd0), 8'h12);
        cyc(3); check_value("ldi1_cont", 32'(cont), 4);

        // ALU R2 <- f3(R1, R5), ready sampled on third EXEC cycle
        snap = inicio_cnt;
        issue(enc(3'b011, 3'd2, 3'd1, 3'd5, 3'd3), 8'h00);
        cyc(4); check_value("alu_inicio", 32'(alu_inicio), 1);
        check_value("alu_a", 32'(alu_a), 32'h12);
        check_value("alu_b", 32'(alu_b), 32'hE7);
        check_value("alu_func", 32'(alu_func), 3);
        cyc(1); check_value("alu_inicio_pulse", 32'(alu_inicio), 0);
        check_value("alu_a_held", 32'(alu_a), 32'h12);
        cyc(1); check_value("alu_b_held", 32'(alu_b), 32'hE7);
        alu_listo = 1'b1; alu_res = 8'h3C;
        @(posedge clk); #1;
        alu_listo = 1'b0; alu_res = '0;
        cyc(1); check_value("alu_wr_cmd", 32'(cmd), 1);
        check_value("alu_wr_addr", 32'(sel_wr), 2);
        check_value("alu_wr_data", 32'(datos), 32'h3C);
        cyc(1); check_value("alu_fin", 32'(fin), 1);
        check_value("alu_cont", 32'(cont), 5);
        #1; check_value("alu_inicio_count", 32'(inicio_cnt - snap), 1);

        // ALU timeout: 15 EXEC cycles (4..18), error on cycle 19
        snap = wr_cnt;
        issue(enc(3'b011, 3'd4, 3'd1, 3'd3, 3'd1), 8'h00);
        cyc(18); check_value("to_c18_err", 32'(error), 0);
        cyc(1); check_value("to_err", 32'(error), 1);
        check_value("to_idle", 32'(lista), 1);
        cyc(1); check_value("to_err_pulse", 32'(error), 0);
        check_value("to_cont", 32'(cont), 5);
        #1; check_value("to_no_write", 32'(wr_cnt - snap), 0);

        // Illegal op 110
        issue(enc(3'b110, 3'd1, 3'd2, 3'd3, 3'd0), 8'h55);
        cyc(1); check_value("ill_err", 32'(error), 1);
        check_value("ill_cmd", 32'(cmd), 0);
        cyc(1); check_value("ill_err_pulse", 32'(error), 0);
        check_value("ill_idle", 32'(lista), 1);
        check_value("ill_cont", 32'(cont), 5);

        // Reset mid-cycle during the CAPTURE cycle of a MOV
        snap = wr_cnt;
        issue(enc(3'b010, 3'd6, 3'd3, 3'd0, 3'd0), 8'h00);
        cyc(3);
        #2 rst = 1'b1;
        #1;
        check_value("mid_rst_lista", 32'(lista), 0);
        check_value("mid_rst_cont", 32'(cont), 0);
        check_value("mid_rst_dout", 32'(dato_sal), 0);
        check_value("mid_rst_cmd", 32'(cmd), 0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        #1; check_value("mid_rst_no_write", 32'(wr_cnt - snap), 0);
        check_value("mid_rst_idle", 32'(lista), 1);

        // 256 NOPs: counter wraps back to 0
        snap = fin_cnt;
        issue(enc(3'b000, 3'd0, 3'd0, 3'd0, 3'd0), 8'h00);
        cyc(1); check_value("nop_c1_fin", 32'(fin), 0);
        cyc(1); check_value("nop_c2_fin", 32'(fin), 1);
        for (int i = 0; i < 254; i++) begin
            issue(enc(3'b000, 3'd0, 3'd0, 3'd0, 3'd0), 8'h00);
            cyc(2);
        end
        check_value("nop_cont_255", 32'(cont), 255);
        issue(enc(3'b000, 3'd0, 3'd0, 3'd0, 3'd0), 8'h00);
        cyc(2); check_value("nop_wrap", 32'(cont), 0);
        #1; check_value("nop_fin_count", 32'(fin_cnt - snap), 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_registros.md
Name: secuenciador_registros

Overview:
Micro-sequencer that drives the 8x8-bit data register file (Registro_de_datos). It accepts one instruction at a time over a valid/ready handshake and decodes it. It then sequences the register-file read, an optional external ALU operation, and write-back. It sits between instruction fetch and the register file/ALU pair.

Parameters:
ALU_TIMEOUT, 15, max cycles EXEC waits for i_ALU_listo before aborting (1..255)

Ports:
i_Timming  in  1  clock, rising edge
i_Rst  in  1  asynchronous reset, active-high
i_Instruccion  in  16  [15:13] op, [12:10] rd, [9:7] rx, [6:4] ry, [3:1] ALU func, [0] unused
i_Inmediato  in  8  immediate for LDI, latched with instruction
i_Inst_valida  in  1  instruction offered
o_Inst_lista  out  1  sequencer ready (IDLE only)
o_Lectura_escritura  out  2  regfile command: 00 hold, 01 write, 10 read
o_Control_RX  out  3  regfile RX read address
o_Control_RY  out  3  regfile RY read address
o_Seleccion_registro_escritura  out  3  regfile write address
o_Seleccion_registro_lectura  out  3  mirrors o_Control_RX during READ, else 0
o_Datos  out  8  regfile write data
i_RX  in  8  regfile RX output
i_RY  in  8  regfile RY output
o_ALU_A, o_ALU_B  out  8 each  ALU operands
o_ALU_func  out  3  ALU function
o_ALU_inicio  out  1  one-cycle ALU start pulse
i_ALU_listo  in  1  ALU result valid
i_ALU_resultado  in  8  ALU result
o_Dato_salida  out  8  OUT result, held until next OUT
o_Salida_valida  out  1  one-cycle pulse with new o_Dato_salida
o_Fin  out  1  one-cycle pulse per completed instruction
o_Error  out  1  one-cycle pulse: illegal op or ALU timeout
o_Contador_inst  out  8  completed-instruction count, wraps 255->0

Behaviour:
- Reset (async, i_Rst=1): state IDLE; every output 0, including o_Inst_lista. Internal latches and the timeout counter clear. After reset release, o_Inst_lista=1 from the first IDLE cycle.
- Ops: 000 NOP, 001 LDI (rd<=imm), 010 MOV (rd<=R[rx]), 011 ALU (rd<=f(R[rx],R[ry])), 100 OUT (o_Dato_salida<=R[rx]), 101-111 illegal.
- IDLE: o_Inst_lista=1. On an edge with i_Inst_valida=1, latch instruction and immediate, then go to DECODE. i_Inst_valida is ignored in all other states.
- DECODE (1 cycle): illegal -> o_Error pulse, return to IDLE, counter unchanged. NOP -> DONE. LDI -> WRITE. MOV/ALU/OUT -> READ.
- READ (1 cycle): o_Lectura_escritura=10, o_Control_RX=rx, o_Control_RY=ry. Register-file outputs are valid the following cycle.
- CAPTURE (1 cycle): sample i_RX and i_RY into operand registers. MOV -> WRITE. OUT -> DONE, with o_Dato_salida updated and o_Salida_valida pulsed on the DONE cycle. ALU -> EXEC.
- EXEC: o_ALU_A/B/func stable throughout EXEC. o_ALU_inicio=1 on the first EXEC cycle only.
  - If i_ALU_listo=1 is sampled (earliest on the first EXEC cycle), latch i_ALU_resultado and go to WRITE.
  - Waited cycles are counted. When ALU_TIMEOUT cycles pass with no i_ALU_listo: o_Error pulse, return to IDLE, no write, counter unchanged.
- WRITE (1 cycle): o_Lectura_escritura=01, o_Seleccion_registro_escritura=rd, o_Datos=value (imm, R[rx] or ALU result). Then DONE.
- DONE (1 cycle): o_Fin=1, o_Contador_inst+1 (wrapping), then IDLE.
- In every state other than READ/WRITE, o_Lectura_escritura=00 and the address outputs are 0.
- Latency from accept edge to the o_Fin cycle: NOP 2, LDI 3, OUT 4, MOV 5, ALU 6+k (k = ALU wait cycles).
- Reset mid-instruction aborts immediately: no write completes and no o_Fin is issued.
- rd=rx is legal (MOV R3,R3 writes the same value). Register 0 has no special treatment.

Decomposition:
- Shared package: op codes (NOP/LDI/MOV/ALU/OUT), register-file command codes (HOLD=00, WRITE=01, READ=10), state encoding, instruction field positions.
- One sub-module, contador_timeout: loadable down-counter with an expiry flag, used by EXEC.
- Everything else lives in a single FSM.

Test Plan:
- Reset: assert i_Rst mid-cycle -> all outputs 0 asynchronously. After release -> o_Inst_lista=1, o_Contador_inst=0.
- LDI rd=3, imm=0xE7 -> WRITE cycle shows cmd=01, write addr=3, o_Datos=0xE7. o_Fin 3 cycles after accept; counter=1.
- MOV rd=5, rx=3 (with i_RX model returning 0xE7) -> READ cmd=10, RX addr=3. WRITE addr=5, data=0xE7. o_Fin at 5 cycles.
- ALU rd=2, rx=1, ry=5, func=3; i_ALU_listo after 2 cycles with result 0x3C -> exactly one o_ALU_inicio pulse, write addr=2 data=0x3C, o_Fin at 8 cycles.
- ALU with i_ALU_listo held 0 -> o_Error after ALU_TIMEOUT cycles in EXEC. No write, counter unchanged, back in IDLE.
- Illegal op 110 -> o_Error 1 cycle after accept, no regfile command. 256 NOPs -> counter wraps to 0. Reset during WRITE-bound MOV -> no cmd=01 issued.
